fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  - Instruction-fetch stage of the pipelined RISC-V core: owns the PC and issues requests to instruction memory.
//  - Captures returned instructions into the IF/ID pipeline register, which feeds decode (Control, Registers, ALUControl).
//  - Honours hazard-unit stalls and branch/jump redirects from EX.
//  - One outstanding memory request at a time.
// PARAMETERS
//  PC_W      64     PC / address width
//  INST_W    32     instruction width
//  RESET_PC  64'h0  PC value loaded on reset
// PORTS
//  clk          in   1       clock, all state on rising edge
//  rst          in   1       synchronous, active-high reset
//  imem_req     out  1       fetch request valid
//  imem_addr    out  PC_W    fetch address; bits[1:0] always 0
//  imem_gnt     in   1       request accepted this cycle
//  imem_rvalid  in   1       read data valid; exactly one per granted request, >=1 cycle after gnt
//  imem_rdata   in   INST_W  instruction returned
//  stall        in   1       decode cannot accept; hold IF/ID
//  redirect     in   1       taken branch/jump: flush and refetch
//  redirect_pc  in   PC_W    redirect target; bits[1:0] ignored (forced 0)
//  ifid_valid   out  1       IF/ID holds a live instruction
//  ifid_pc      out  PC_W    PC of ifid_inst
//  ifid_inst    out  INST_W  instruction to decode
// BEHAVIOUR
//  - Reset (rst=1 at clock edge): pc=RESET_PC, state=S_REQ, kill=0, ifid_valid=0, ifid_pc=0, ifid_inst=NOP (32'h00000013).
//    imem_req=0 while rst is high.
//  - FSM states: S_REQ, S_WAIT, S_HOLD.
//    - S_REQ: imem_req=1, imem_addr=pc. Addr stable until gnt. On gnt -> S_WAIT.
//    - S_WAIT: imem_req=0. On rvalid:
//      - if kill: discard data, kill<=0, -> S_REQ;
//      - else if IF/ID free (!ifid_valid || !stall): load IF/ID, pc<=pc+4, -> S_REQ;
//      - else: store in skid reg, pc<=pc+4, -> S_HOLD.
//    - S_HOLD: imem_req=0. When !stall: move skid to IF/ID (valid=1), -> S_REQ.
//  - IF/ID register:
//    - holds value while stall && ifid_valid;
//    - when !stall and no new instruction arrives, ifid_valid<=0 (bubble); pc/inst hold their last values.
//  - Redirect takes priority over every other event in the same cycle:
//    - pc<=redirect_pc & ~3; ifid_valid<=0; skid dropped.
//    - S_REQ with gnt same cycle -> S_WAIT, kill=1. S_REQ without gnt -> stays S_REQ; new address from next cycle.
//    - S_WAIT without rvalid -> kill=1. S_WAIT with rvalid same cycle -> data discarded, -> S_REQ.
//    - S_HOLD -> S_REQ.
//  - Redirect and stall together: redirect wins (IF/ID flushed).
//  - Latency: IF/ID loads on the edge that samples rvalid; minimum 2 cycles from req to ifid_valid with 1-cycle memory.
//  - pc+4 is modulo 2^PC_W (wraps from all-ones-minus-3 to 0, no flag).
//  - Throughput: 1 instruction per (gnt-to-rvalid latency + 1) cycles; no prefetch beyond one request.
// CONFIGURATION
//  - FETCH_PERF_CNT_EN defined:
//    - extra port fetch_count out 32, reset 0;
//    - increments once per instruction loaded into IF/ID (killed fetches not counted);
//    - wraps at 2^32.
//  - FETCH_PERF_CNT_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  - riscv_pkg: fetch_state_e enum {S_REQ,S_WAIT,S_HOLD}, NOP_INST constant, INST_W/PC_W defaults.
//  - Sub-module if_id_reg: IF/ID register with load/hold/flush controls. Instantiated once; FSM, PC and skid stay in fetch_stage.
// TESTING
//  - Reset RESET_PC=64'h1000, memory gnt same cycle, rvalid next cycle:
//    addrs 0x1000, 0x1004, 0x1008 issued; ifid_pc follows with ifid_valid=1.
//  - stall=1 for 3 cycles while ifid holds 0x1004:
//    next instruction (0x1008) parked in skid; ifid unchanged; no imem_req;
//    on stall release ifid_pc=0x1008 next edge.
//  - redirect to 0x2002 in S_WAIT with rvalid 2 cycles later:
//    returned data discarded; next imem_addr=0x2000; ifid_valid=0 until 0x2000 returns.
//  - redirect and rvalid in same cycle: data dropped; imem_req to redirect target next cycle; ifid_valid=0.
//  - PC wrap: RESET_PC=64'hFFFF_FFFF_FFFF_FFFC -> second fetch addr 0x0.
//    With FETCH_PERF_CNT_EN, fetch_count=2 after two loads.
//  - rst asserted in S_WAIT:
//    all outputs return to reset values next edge; late rvalid after rst drop while in S_REQ is ignored.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared types and constants for the RISC-V core front end.
// Holds the fetch FSM encoding, the NOP constant and the default widths.
package riscv_pkg;

  localparam int unsigned PC_W_DEFAULT   = 64;
  localparam int unsigned INST_W_DEFAULT = 32;

  // addi x0, x0, 0
  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_HOLD
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register between fetch and decode.
// Flush beats load, and load beats hold. A bubble clears only the valid bit.
module if_id_reg
  import riscv_pkg::*;
#(
  parameter int unsigned PC_W   = PC_W_DEFAULT,
  parameter int unsigned INST_W = INST_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_i,
  input  logic              flush_i,
  input  logic              stall_i,
  input  logic [PC_W-1:0]   pc_i,
  input  logic [INST_W-1:0] inst_i,
  output logic              valid_o,
  output logic [PC_W-1:0]   pc_o,
  output logic [INST_W-1:0] inst_o
);

  logic              valid_q, valid_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [INST_W-1:0] inst_q, inst_d;

  always_comb begin
    valid_d = valid_q;
    pc_d    = pc_q;
    inst_d  = inst_q;
    if (flush_i) begin
      valid_d = 1'b0;
    end else if (load_i) begin
      valid_d = 1'b1;
      pc_d    = pc_i;
      inst_d  = inst_i;
    end else if (!stall_i) begin
      // Decode consumed the entry and nothing replaces it.
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      inst_q  <= INST_W'(NOP_INST);
    end else begin
      valid_q <= valid_d;
      pc_q    <= pc_d;
      inst_q  <= inst_d;
    end
  end

  assign valid_o = valid_q;
  assign pc_o    = pc_q;
  assign inst_o  = inst_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: owns the PC, issues one memory request at a time, fills IF/ID.
// Optional fetch counter port is enabled with the FETCH_PERF_CNT_EN macro.
module fetch_stage
  import riscv_pkg::*;
#(
  parameter int unsigned     PC_W     = PC_W_DEFAULT,
  parameter int unsigned     INST_W   = INST_W_DEFAULT,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              ifid_valid,
  output logic [PC_W-1:0]   ifid_pc,
  output logic [INST_W-1:0] ifid_inst
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]       fetch_count
`endif
);

  fetch_state_e      state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              kill_q, kill_d;
  logic [PC_W-1:0]   skid_pc_q, skid_pc_d;
  logic [INST_W-1:0] skid_inst_q, skid_inst_d;

  logic              ifid_load;
  logic              ifid_flush;
  logic [PC_W-1:0]   ifid_load_pc;
  logic [INST_W-1:0] ifid_load_inst;
  logic              ifid_free;

  assign ifid_free = !ifid_valid || !stall;

  always_comb begin
    state_d        = state_q;
    pc_d           = pc_q;
    kill_d         = kill_q;
    skid_pc_d      = skid_pc_q;
    skid_inst_d    = skid_inst_q;
    ifid_load      = 1'b0;
    ifid_flush     = 1'b0;
    ifid_load_pc   = pc_q;
    ifid_load_inst = imem_rdata;

    if (redirect) begin
      pc_d       = redirect_pc & ~PC_W'(3);
      ifid_flush = 1'b1;
      unique case (state_q)
        S_REQ: begin
          // A request accepted this cycle is still in flight and must be discarded.
          if (imem_gnt) begin
            state_d = S_WAIT;
            kill_d  = 1'b1;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            state_d = S_REQ;
            kill_d  = 1'b0;
          end else begin
            kill_d  = 1'b1;
          end
        end
        S_HOLD:  state_d = S_REQ;
        default: state_d = S_REQ;
      endcase
    end else begin
      unique case (state_q)
        S_REQ: begin
          if (imem_gnt) state_d = S_WAIT;
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            if (kill_q) begin
              kill_d  = 1'b0;
              state_d = S_REQ;
            end else if (ifid_free) begin
              ifid_load = 1'b1;
              pc_d      = pc_q + PC_W'(4);
              state_d   = S_REQ;
            end else begin
              skid_pc_d   = pc_q;
              skid_inst_d = imem_rdata;
              pc_d        = pc_q + PC_W'(4);
              state_d     = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          if (!stall) begin
            ifid_load      = 1'b1;
            ifid_load_pc   = skid_pc_q;
            ifid_load_inst = skid_inst_q;
            state_d        = S_REQ;
          end
        end
        default: state_d = S_REQ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_REQ;
      pc_q        <= RESET_PC & ~PC_W'(3);
      kill_q      <= 1'b0;
      skid_pc_q   <= '0;
      skid_inst_q <= INST_W'(NOP_INST);
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      kill_q      <= kill_d;
      skid_pc_q   <= skid_pc_d;
      skid_inst_q <= skid_inst_d;
    end
  end

  assign imem_req  = (state_q == S_REQ) && !rst;
  assign imem_addr = pc_q;

  if_id_reg #(
    .PC_W  (PC_W),
    .INST_W(INST_W)
  ) u_if_id_reg (
    .clk    (clk),
    .rst    (rst),
    .load_i (ifid_load),
    .flush_i(ifid_flush),
    .stall_i(stall),
    .pc_i   (ifid_load_pc),
    .inst_i (ifid_load_inst),
    .valid_o(ifid_valid),
    .pc_o   (ifid_pc),
    .inst_o (ifid_inst)
  );

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] count_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else if (ifid_load) begin
      count_q <= count_q + 32'd1;
    end
  end

  assign fetch_count = count_q;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Bench for fetch_stage: a latency-randomised instruction memory plus a queue-based
// model of what decode should see, compared every cycle with immediate assertions.
module tb_fetch_stage;

  localparam logic [63:0] RST_PC = 64'h1000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        ifid_valid;
  logic [63:0] ifid_pc;
  logic [31:0] ifid_inst;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_count;
`endif

  always #5 clk = ~clk;

  fetch_stage #(
    .PC_W    (64),
    .INST_W  (32),
    .RESET_PC(RST_PC)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_gnt   (imem_gnt),
    .imem_rvalid(imem_rvalid),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .ifid_valid (ifid_valid),
    .ifid_pc    (ifid_pc),
    .ifid_inst  (ifid_inst)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_count(fetch_count)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Memory behaviour knobs.
  int gnt_pct = 100;
  int lat_min = 0;
  int lat_max = 0;

  // Memory state: one live request, plus a request orphaned by reset.
  bit          mem_busy   = 1'b0;
  int          mem_lat    = 0;
  logic [63:0] mem_addr   = '0;
  bit          mem_killed = 1'b0;
  bit          stale      = 1'b0;
  int          stale_lat  = 0;
  bit          last_gnt   = 1'b0;

  // Reference model of the fetch address and of what decode sees.
  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] inst;
  } ent_t;

  logic [63:0] exp_addr = RST_PC;
  bit          m_valid  = 1'b0;
  logic [63:0] m_pc     = '0;
  logic [31:0] m_inst   = NOP;
  logic [31:0] m_count  = '0;
  ent_t        pend[$];

  function automatic logic [31:0] inst_of(input logic [63:0] a);
    return a[31:0] ^ a[63:32] ^ 32'h5A5A_0013;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock cycle; stall/redirect/rst for this cycle are already driven by the caller.
  task automatic cycle();
    bit   exp_req;
    bit   arrive;
    ent_t a;
    ent_t e;

    #1;
    imem_gnt    = imem_req && !stale && ($urandom_range(99) < 32'(gnt_pct));
    imem_rvalid = (mem_busy && mem_lat == 0) || (stale && stale_lat == 0 && !rst);
    imem_rdata  = mem_busy ? inst_of(mem_addr) : 32'hDEAD_BEEF;
    #1;

    exp_req = !rst && !mem_busy && pend.size() == 0;
    check("imem_req", {63'd0, imem_req}, {63'd0, exp_req});
    if (exp_req) check("imem_addr", imem_addr, exp_addr);

    last_gnt = imem_req && imem_gnt && !rst;
    if (stale) begin
      if (imem_rvalid) stale = 1'b0;
      else if (stale_lat > 0) stale_lat--;
    end

    if (rst) begin
      if (mem_busy && mem_lat > 0) begin
        stale     = 1'b1;
        stale_lat = mem_lat - 1;
      end
      mem_busy = 1'b0;
      exp_addr = RST_PC;
      m_valid  = 1'b0;
      m_pc     = '0;
      m_inst   = NOP;
      m_count  = '0;
      pend.delete();
    end else begin
      arrive = 1'b0;
      if (mem_busy) begin
        if (mem_lat == 0) begin
          mem_busy = 1'b0;
          if (!mem_killed && !redirect) begin
            arrive = 1'b1;
            a      = '{pc: mem_addr, inst: inst_of(mem_addr)};
          end
        end else begin
          mem_lat--;
        end
      end
      if (imem_req && imem_gnt) begin
        mem_busy   = 1'b1;
        mem_addr   = exp_addr;
        mem_killed = redirect;
        mem_lat    = int'($urandom_range(lat_max, lat_min));
        exp_addr   = exp_addr + 64'd4;
      end
      if (redirect) begin
        mem_killed = 1'b1;
        exp_addr   = redirect_pc & ~64'h3;
        m_valid    = 1'b0;
        pend.delete();
      end else begin
        if (arrive) pend.push_back(a);
        if (!m_valid || !stall) begin
          if (pend.size() > 0) begin
            e       = pend.pop_front();
            m_valid = 1'b1;
            m_pc    = e.pc;
            m_inst  = e.inst;
            m_count = m_count + 32'd1;
          end else begin
            m_valid = 1'b0;
          end
        end
      end
    end

    @(posedge clk);
    #1;
    check("ifid_valid", {63'd0, ifid_valid}, {63'd0, m_valid});
    check("ifid_pc", ifid_pc, m_pc);
    check("ifid_inst", {32'd0, ifid_inst}, {32'd0, m_inst});
`ifdef FETCH_PERF_CNT_EN
    check("fetch_count", {32'd0, fetch_count}, {32'd0, m_count});
`endif
  endtask

  // Run until the memory accepts a request, bounded.
  task automatic wait_grant();
    bit seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      cycle();
      seen = last_gnt;
    end
    check("grant_seen", {63'd0, seen}, 64'd1);
  endtask

  initial begin
    rst         = 1'b1;
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = '0;
    imem_gnt    = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata  = '0;
    #1;

    // Reset, then a 1-cycle memory streaming 0x1000, 0x1004, 0x1008...
    repeat (2) cycle();
    rst = 1'b0;
    repeat (8) cycle();

    // Stall three cycles: next fetch parks in the skid, no new requests.
    stall = 1'b1;
    repeat (3) cycle();
    stall = 1'b0;
    repeat (4) cycle();

    // Redirect while waiting, data arrives two cycles later and is discarded.
    lat_min = 2;
    lat_max = 2;
    wait_grant();
    redirect    = 1'b1;
    redirect_pc = 64'h2002;
    cycle();
    redirect = 1'b0;
    repeat (8) cycle();

    // Redirect coinciding with rvalid.
    lat_min = 0;
    lat_max = 0;
    wait_grant();
    redirect    = 1'b1;
    redirect_pc = 64'h3000;
    cycle();
    redirect = 1'b0;
    repeat (4) cycle();

    // Redirect coinciding with a grant.
    wait_grant();
    cycle();
    redirect    = 1'b1;
    redirect_pc = 64'h4004;
    cycle();
    redirect = 1'b0;
    repeat (4) cycle();

    // Redirect together with stall while an instruction sits in the skid.
    stall = 1'b1;
    repeat (3) cycle();
    redirect    = 1'b1;
    redirect_pc = 64'h5008;
    cycle();
    redirect = 1'b0;
    cycle();
    stall = 1'b0;
    repeat (4) cycle();

    // PC wrap past the top of the address space.
    redirect    = 1'b1;
    redirect_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    cycle();
    redirect = 1'b0;
    repeat (6) cycle();

    // Reset while waiting; the orphaned rvalid later arrives in S_REQ.
    lat_min = 2;
    lat_max = 2;
    wait_grant();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    repeat (8) cycle();

    // Randomised traffic.
    gnt_pct = 70;
    lat_min = 0;
    lat_max = 2;
    for (int i = 0; i < 800; i++) begin
      stall       = ($urandom_range(99) < 30);
      redirect    = ($urandom_range(99) < 5);
      redirect_pc = {$urandom, $urandom};
      rst         = ($urandom_range(199) == 0);
      cycle();
    end
    stall    = 1'b0;
    redirect = 1'b0;
    rst      = 1'b0;
    repeat (4) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
